// File: rtl/hazard_pkg.sv
// Shared register-index widths, FSM encoding and shadow-slot types for the
// hazard detection unit.
package hazard_pkg;
  localparam int                   REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO  = 5'd0;
  localparam int                   NUM_SRC   = 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
    logic                 memread;
  } ex_slot_t;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 regwrite;
  } mem_slot_t;
endpackage

// File: rtl/hazard_detect_if.sv
// Decode-side request and hazard/forward response bundle of hazard_detect.
interface hazard_detect_if;
  logic                            D_valid;
  logic [hazard_pkg::REG_IDX_W-1:0] D_rs1;
  logic [hazard_pkg::REG_IDX_W-1:0] D_rs2;
  logic                            D_rs1_used;
  logic                            D_rs2_used;
  logic [hazard_pkg::REG_IDX_W-1:0] D_rd;
  logic                            D_RegWrite;
  logic                            D_MemRead;
  logic                            branch_taken;
  logic                            E_rs1_forward;
  logic                            E_rs2_forward;
  logic                            M_rs1_forward;
  logic                            M_rs2_forward;
  logic                            stall;
  logic                            flush_D;
  logic                            flush_E;

  modport master (
    output D_valid, D_rs1, D_rs2, D_rs1_used, D_rs2_used, D_rd,
           D_RegWrite, D_MemRead, branch_taken,
    input  E_rs1_forward, E_rs2_forward, M_rs1_forward, M_rs2_forward,
           stall, flush_D, flush_E
  );

  modport slave (
    input  D_valid, D_rs1, D_rs2, D_rs1_used, D_rs2_used, D_rd,
           D_RegWrite, D_MemRead, branch_taken,
    output E_rs1_forward, E_rs2_forward, M_rs1_forward, M_rs2_forward,
           stall, flush_D, flush_E
  );
endinterface

// File: rtl/hazard_detect_reg_match.sv
// One producer-slot vs one consumer-source comparison; x0 never matches.
module reg_match
  import hazard_pkg::*;
(
  input  logic                 i_valid,
  input  logic                 i_regwrite,
  input  logic [REG_IDX_W-1:0] i_rd,
  input  logic [REG_IDX_W-1:0] i_rs,
  input  logic                 i_used,
  output logic                 o_hit
);
  assign o_hit = i_used && i_valid && i_regwrite &&
                 (i_rs != REG_ZERO) && (i_rd == i_rs);
endmodule

// File: rtl/hazard_detect.sv
// Load-use stall, branch flush and registered EX/MEM forward selection.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  hazard_detect_if.slave  hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]     stall_cnt,
  output logic [15:0]     flush_cnt
`endif
);
  ex_slot_t                          r_ex;
  mem_slot_t                         r_mem;
  hz_state_e                         r_state;
  logic [NUM_SRC-1:0]                r_e_fwd;
  logic [NUM_SRC-1:0]                r_m_fwd;

  logic [NUM_SRC-1:0][REG_IDX_W-1:0] w_rs;
  logic [NUM_SRC-1:0]                w_used;
  logic [NUM_SRC-1:0]                w_e_hit;
  logic [NUM_SRC-1:0]                w_m_hit;
  logic                              w_stall;
  logic                              w_flush;
  logic                              w_load_ex;

  assign w_rs   = {hz.D_rs2, hz.D_rs1};
  assign w_used = {hz.D_rs2_used, hz.D_rs1_used};

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    reg_match u_ex (
      .i_valid    (r_ex.valid),
      .i_regwrite (r_ex.regwrite),
      .i_rd       (r_ex.rd),
      .i_rs       (w_rs[s]),
      .i_used     (w_used[s]),
      .o_hit      (w_e_hit[s])
    );
    reg_match u_mem (
      .i_valid    (r_mem.valid),
      .i_regwrite (r_mem.regwrite),
      .i_rd       (r_mem.rd),
      .i_rs       (w_rs[s]),
      .i_used     (w_used[s]),
      .o_hit      (w_m_hit[s])
    );
  end

  // A load in EX can only be waited on from RUN; the inserted bubble clears it.
  assign w_stall   = !rst && hz.D_valid && !hz.branch_taken && (r_state == RUN) &&
                     r_ex.memread && (|w_e_hit);
  assign w_flush   = !rst && hz.branch_taken;
  assign w_load_ex = hz.D_valid && !w_stall && !hz.branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_e_fwd <= '0;
      r_m_fwd <= '0;
    end else begin
      r_mem <= '{valid: r_ex.valid, rd: r_ex.rd, regwrite: r_ex.regwrite};
      if (w_load_ex) begin
        r_ex    <= '{valid: 1'b1, rd: hz.D_rd, regwrite: hz.D_RegWrite,
                     memread: hz.D_MemRead};
        r_e_fwd <= w_e_hit;
        r_m_fwd <= w_m_hit & ~w_e_hit;
      end else begin
        r_ex    <= '0;
        r_e_fwd <= '0;
        r_m_fwd <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     r_state <= hz.branch_taken ? FLUSH : (w_stall ? STALL : RUN);
        STALL:   r_state <= hz.branch_taken ? FLUSH : RUN;
        FLUSH:   r_state <= hz.branch_taken ? FLUSH : RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  assign hz.stall         = w_stall;
  assign hz.flush_D       = w_flush;
  assign hz.flush_E       = w_flush;
  assign hz.E_rs1_forward = r_e_fwd[0];
  assign hz.E_rs2_forward = r_e_fwd[1];
  assign hz.M_rs1_forward = r_m_fwd[0];
  assign hz.M_rs2_forward = r_m_fwd[1];

`ifdef HAZARD_PERF_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
`endif
endmodule

// File: tb/tb_hazard_detect.sv
// Directed vector table plus hand sequences for reset-in-stall and perf counters.
module tb_hazard_detect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  hazard_detect_if hif ();
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  hazard_detect dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, mr, br;
    logic       st, fl;
    logic [3:0] fwd;  // {E1,E2,M1,M2} registered at the end of this cycle
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic br);
    hif.D_valid = v;   hif.D_rs1 = rs1; hif.D_rs2 = rs2;
    hif.D_rs1_used = u1; hif.D_rs2_used = u2; hif.D_rd = rd;
    hif.D_RegWrite = rw; hif.D_MemRead = mr; hif.branch_taken = br;
  endtask

  function automatic logic [3:0] fwd_now();
    return {hif.E_rs1_forward, hif.E_rs2_forward, hif.M_rs1_forward, hif.M_rs2_forward};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          v  rs1 rs2 u1 u2 rd  rw mr br  st fl fwd
    vecs[0]  = '{1, 1,  2,  1, 1, 5,  1, 0, 0,  0, 0, 4'b0000}; // add x5,x1,x2
    vecs[1]  = '{1, 5,  1,  1, 1, 6,  1, 0, 0,  0, 0, 4'b1000}; // sub x6,x5,x1
    vecs[2]  = '{1, 1,  2,  1, 1, 10, 1, 0, 0,  0, 0, 4'b0000}; // add x10
    vecs[3]  = '{0, 0,  0,  0, 0, 0,  0, 0, 0,  0, 0, 4'b0000}; // nop
    vecs[4]  = '{1, 1,  10, 1, 1, 7,  1, 0, 0,  0, 0, 4'b0001}; // or x7,x1,x10
    vecs[5]  = '{1, 2,  0,  1, 0, 8,  1, 1, 0,  0, 0, 4'b0000}; // lw x8
    vecs[6]  = '{1, 8,  8,  1, 1, 9,  1, 0, 0,  1, 0, 4'b0000}; // add x9,x8,x8 stalls
    vecs[7]  = '{1, 8,  8,  1, 1, 9,  1, 0, 0,  0, 0, 4'b0011}; // held, forwards via MEM
    vecs[8]  = '{1, 1,  2,  1, 1, 0,  1, 0, 0,  0, 0, 4'b0000}; // add x0
    vecs[9]  = '{1, 0,  0,  1, 1, 11, 1, 0, 0,  0, 0, 4'b0000}; // use x0
    vecs[10] = '{1, 3,  0,  1, 0, 8,  1, 1, 0,  0, 0, 4'b0000}; // lw x8
    vecs[11] = '{1, 8,  8,  1, 1, 9,  1, 0, 1,  0, 1, 4'b0000}; // dependent + branch
    vecs[12] = '{1, 9,  1,  1, 1, 12, 1, 0, 0,  0, 0, 4'b0000}; // x9 producer was squashed
    vecs[13] = '{1, 1,  0,  1, 0, 0,  1, 1, 0,  0, 0, 4'b0000}; // lw x0
    vecs[14] = '{1, 0,  0,  1, 1, 13, 1, 0, 0,  0, 0, 4'b0000}; // use x0 after lw x0

    // Reset state, with a branch request that must stay masked.
    drive(1, 8, 8, 1, 1, 9, 1, 1, 1);
    step(); step();
    chk("rst_fwd",     32'(fwd_now()), 32'h0);
    chk("rst_stall",   32'(hif.stall), 32'h0);
    chk("rst_flush_D", 32'(hif.flush_D), 32'h0);
    chk("rst_flush_E", 32'(hif.flush_E), 32'h0);
`ifdef HAZARD_PERF_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
            vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].br);
      #1;
      chk($sformatf("v%0d_stall", i),   32'(hif.stall),   32'(vecs[i].st));
      chk($sformatf("v%0d_flush_D", i), 32'(hif.flush_D), 32'(vecs[i].fl));
      chk($sformatf("v%0d_flush_E", i), 32'(hif.flush_E), 32'(vecs[i].fl));
      step();
      chk($sformatf("v%0d_fwd", i),     32'(fwd_now()),   32'(vecs[i].fwd));
    end

    // Reset asserted while in STALL: outputs masked, slots cleared.
    drive(1, 2, 0, 1, 0, 8, 1, 1, 0); #1; step();
    drive(1, 8, 8, 1, 1, 9, 1, 0, 0); #1;
    chk("rs_stall_pre", 32'(hif.stall), 32'h1);
    step();
    rst = 1'b1;
    hif.branch_taken = 1'b1;
    #1;
    chk("rs_stall_in_rst", 32'(hif.stall),   32'h0);
    chk("rs_flushD_in_rst", 32'(hif.flush_D), 32'h0);
    step();
    chk("rs_fwd_after_rst", 32'(fwd_now()), 32'h0);
    rst = 1'b0;
    hif.branch_taken = 1'b0;
    #1;
    chk("rs_stall_post", 32'(hif.stall), 32'h0);
    step();
    chk("rs_fwd_post", 32'(fwd_now()), 32'h0);

`ifdef HAZARD_PERF_EN
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 2, 0, 1, 0, 8, 1, 1, 0); step();
      drive(1, 8, 8, 1, 1, 9, 1, 0, 0); step();  // stall cycle
      step();                                    // dependent proceeds
    end
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    end
    chk("perf_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("perf_flush_cnt", 32'(flush_cnt), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_detect.md
HAZARD_DETECT -- requirements
Module: hazard_detect

Interface
REQ-001 SHALL: clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: D_valid  in  1  decode stage holds a valid instruction.
REQ-004 SHALL: D_rs1, D_rs2  in  5 each  decode source register indices.
REQ-005 SHALL: D_rs1_used, D_rs2_used  in  1 each  source actually read by the instruction.
REQ-006 SHALL: D_rd  in  5  decode destination index.
REQ-007 SHALL: D_RegWrite  in  1  instruction writes rd.
REQ-008 SHALL: D_MemRead  in  1  instruction is a load.
REQ-009 SHALL: branch_taken  in  1  EX-stage redirect this cycle.
REQ-010 SHALL: E_rs1_forward, E_rs2_forward  out  1 each  registered; EX instruction takes operand from EX/MEM register.
REQ-011 SHALL: M_rs1_forward, M_rs2_forward  out  1 each  registered; EX instruction takes operand from MEM/WB register.
REQ-012 SHALL: stall  out  1  hold PC and IF/ID register this cycle.
REQ-013 SHALL: flush_D, flush_E  out  1 each  squash IF/ID and ID/EX contents this cycle.

Function
REQ-014 SHALL track two shadow slots, EX {valid, rd, RegWrite, MemRead} and MEM {valid, rd, RegWrite}, advancing EX->MEM each cycle.
REQ-015 SHALL load EX slot from D_* when D_valid && !stall && !branch_taken; otherwise load EX slot as bubble (valid=0).
REQ-016 SHALL, on the same edge the EX slot loads, register E_rsN_forward = D_rsN_used && D_rsN!=0 && EXslot.valid && EXslot.RegWrite && EXslot.rd==D_rsN.
REQ-017 SHALL register M_rsN_forward with the same rule against MEM slot, forced 0 when E_rsN_forward is set (EX/MEM priority).
REQ-018 SHALL clear all four forward flags on any edge where the EX slot loads a bubble.
REQ-019 SHALL assert stall combinationally (zero latency) when D_valid and a used nonzero rsN matches a valid EX-slot load (MemRead=1) with RegWrite=1.
REQ-020 SHALL implement FSM RUN/STALL/FLUSH: RUN->STALL on load-use stall; STALL->RUN after exactly one cycle; any state->FLUSH on branch_taken; FLUSH->RUN next cycle.
REQ-021 SHALL never assert stall for more than one consecutive cycle per load (bubble removes the hazard; the load then forwards via M path).
REQ-022 SHALL assert flush_D and flush_E in the branch_taken cycle; branch_taken SHALL override stall (stall=0 that cycle).
REQ-023 SHALL treat register 0 as never hazarding: no forward, no stall.
REQ-024 SHALL, in FLUSH, keep stall=0 and forward flags 0 for the squashed slot.

Reset
REQ-025 SHALL, while rst=1 at an edge, clear both slots' valid, all forward flags to 0, FSM to RUN.
REQ-026 SHALL drive stall, flush_D, flush_E to 0 while rst=1, including a reset asserted during STALL or FLUSH.

Configuration
REQ-027 SHALL honour macro HAZARD_PERF_EN: when defined, add outputs stall_cnt[15:0] and flush_cnt[15:0], incremented on each stall/flush cycle, saturating at 16'hFFFF, cleared by rst.
REQ-028 SHALL, without HAZARD_PERF_EN, omit those ports and counters entirely, other behaviour identical.

Structure
REQ-029 SHALL place REG_IDX_W=5, REG_ZERO=5'd0 and the RUN/STALL/FLUSH state encoding in shared package hazard_pkg.
REQ-030 SHALL use one sub-module reg_match (valid, RegWrite, rd, rs, used -> hit, x0 suppressed), instanced per slot/source pair.

Verification
REQ-031 SHALL cover: add x5 then sub x6,x5,x1 back-to-back -> E_rs1_forward=1, M_rs1_forward=0 in sub's EX cycle.
REQ-032 SHALL cover: add x5; nop; or x7,x1,x5 -> M_rs2_forward=1, E_rs2_forward=0.
REQ-033 SHALL cover: lw x8; add x9,x8,x8 -> stall=1 exactly one cycle, then M_rs1_forward=M_rs2_forward=1.
REQ-034 SHALL cover: lw x8 with dependent in D and branch_taken same cycle -> stall=0, flush_D=flush_E=1, next EX slot bubble.
REQ-035 SHALL cover: add x0 then use x0 -> no forward, no stall; rst mid-STALL -> stall=0, flags 0 next cycle.
REQ-036 SHALL cover (HAZARD_PERF_EN): 3 load-use stalls, 2 flushes -> stall_cnt=3, flush_cnt=2.
